spi_pwm_core: RTL and testbench

SPI_PWM_CORE -- requirements
Module: spi_pwm_core

---
 rtl/spi_pwm_core.sv | 134 +++++++++++++
 tb/tb_spi_pwm_core.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/spi_pwm_core.sv
// PWM core behind an SPI register stage: prescaler, period counter, shadowed PERIOD/DUTY.
// Optional PWM_DEADTIME_EN adds a complementary pwm_n output with DEAD_CYCLES dead time.
module spi_pwm_core #(
  parameter int DEAD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       pwm_out,
  output logic       pwm_n,
  output logic       period_end,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t     state;
  logic [7:0] ctrl, prescale, period_sh, duty_sh;
  logic [7:0] period_act, duty_act, pcnt, cnt;
  logic [7:0] period_nx, duty_nx;
  logic       active, tick, wrap, raw_nx;

  // Shadow values as seen by a load this cycle, including a same-cycle write
  assign period_nx = (wr_en && wr_addr == 2'd2) ? wr_data : period_sh;
  assign duty_nx   = (wr_en && wr_addr == 2'd3) ? wr_data : duty_sh;

  assign active     = (state != IDLE);
  assign tick       = active && (pcnt == prescale);
  assign wrap       = tick && (cnt == period_act);
  assign period_end = wrap;
  assign busy       = active;
  assign raw_nx     = active && (cnt < duty_act);

  always_comb begin
    rd_data = ctrl;
    case (rd_addr)
      2'd0: rd_data = ctrl;
      2'd1: rd_data = prescale;
      2'd2: rd_data = period_sh;
      2'd3: rd_data = duty_sh;
      default: rd_data = ctrl;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl      <= '0;
      prescale  <= '0;
      period_sh <= '0;
      duty_sh   <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        2'd0: ctrl      <= wr_data;
        2'd1: prescale  <= wr_data;
        2'd2: period_sh <= wr_data;
        2'd3: duty_sh   <= wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pcnt       <= '0;
      cnt        <= '0;
      period_act <= '0;
      duty_act   <= '0;
    end else begin
      case (state)
        IDLE: begin
          pcnt <= '0;
          cnt  <= '0;
          if (ctrl[0]) begin
            state      <= RUN;
            period_act <= period_nx;
            duty_act   <= duty_nx;
          end
        end
        default: begin
          // A shrunk PRESCALE below pcnt just restarts the prescaler
          pcnt <= (pcnt >= prescale) ? 8'd0 : pcnt + 8'd1;
          if (tick) cnt <= wrap ? 8'd0 : cnt + 8'd1;
          if (wrap) begin
            period_act <= period_nx;
            duty_act   <= duty_nx;
          end
          if (state == RUN) begin
            if (!ctrl[0]) state <= STOPPING;
          end else if (ctrl[0]) begin
            state <= RUN;
          end else if (wrap) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef PWM_DEADTIME_EN
  localparam logic [4:0] DEAD = 5'(DEAD_CYCLES);
  logic       raw_q;
  logic [4:0] age, age_nx;

  // age counts cycles the raw level has been stable; an output only asserts past DEAD
  assign age_nx = (raw_nx != raw_q) ? 5'd1 : ((age == 5'd31) ? age : age + 5'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q   <= 1'b0;
      age     <= '0;
      pwm_out <= 1'b0;
      pwm_n   <= 1'b0;
    end else begin
      raw_q   <= raw_nx;
      age     <= age_nx;
      pwm_out <= (raw_nx && (age_nx > DEAD)) ^ ctrl[1];
      pwm_n   <= (active && !raw_nx && (age_nx > DEAD)) ^ ctrl[1];
    end
  end
`else
  logic [31:0] dead_unused;
  assign dead_unused = DEAD_CYCLES;
  assign pwm_n       = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_out <= 1'b0;
    else     pwm_out <= raw_nx ^ ctrl[1];
  end
`endif
endmodule

// File: tb/tb_spi_pwm_core.sv
// Directed bench for spi_pwm_core: a vector table of period/duty configurations
// plus hand sequences for shadow reload, stop/restart, async reset and dead time.
module tb_spi_pwm_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [1:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       pwm_out, pwm_n, period_end, busy;

  int nvec = 0;
  int nerr = 0;

  spi_pwm_core #(.DEAD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .pwm_out(pwm_out), .pwm_n(pwm_n),
    .period_end(period_end), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ps, per, duty, ctrl;
    int         len, hi;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk); wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic start(input logic [7:0] ps, input logic [7:0] per,
                       input logic [7:0] duty, input logic [7:0] ctrl);
    wr(2'd1, ps); wr(2'd2, per); wr(2'd3, duty); wr(2'd0, ctrl);
  endtask

  // Leaves the bench at the negedge inside a wrap cycle
  task automatic sync();
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!period_end && n < 2000);
    if (!period_end) chk("sync timeout", 0, 1);
  endtask

  // Counts one full period window (up to and including the next wrap cycle);
  // optional writes are driven at iterations at1/at2, busy sampled at at2.
  task automatic measure(input int at1, input logic [1:0] a1, input logic [7:0] d1,
                         input int at2, input logic [1:0] a2, input logic [7:0] d2,
                         output int len, output int hi, output int nhi,
                         output int both, output logic b2);
    len = 0; hi = 0; nhi = 0; both = 0; b2 = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk); wr_en = 1'b0;
      len = i;
      if (pwm_out === 1'b1) hi++;
      if (pwm_n === 1'b1) nhi++;
      if (pwm_out === 1'b1 && pwm_n === 1'b1) both++;
      if (i == at2) b2 = busy;
      if (i == at1) begin wr_en = 1'b1; wr_addr = a1; wr_data = d1; end
      if (i == at2) begin wr_en = 1'b1; wr_addr = a2; wr_data = d2; end
      if (period_end) break;
    end
  endtask

  initial begin
    vec_t vt[8];
    int len, hi, nhi, both, cnt_pe;
    logic b2;

    vt[0] = '{8'd0, 8'd9, 8'd3,   8'd1, 10, 3};
    vt[1] = '{8'd3, 8'd4, 8'd0,   8'd1, 20, 0};
    vt[2] = '{8'd3, 8'd4, 8'd255, 8'd1, 20, 20};
    vt[3] = '{8'd0, 8'd0, 8'd0,   8'd1, 1,  0};
    vt[4] = '{8'd0, 8'd0, 8'd1,   8'd1, 1,  1};
    vt[5] = '{8'd1, 8'd9, 8'd10,  8'd1, 20, 20};
    vt[6] = '{8'd2, 8'd5, 8'd5,   8'd1, 18, 15};
    vt[7] = '{8'd0, 8'd9, 8'd3,   8'd3, 10, 7};

    // Reset state
    @(negedge clk);
    chk("rst pwm_out", pwm_out, 0);
    chk("rst pwm_n", pwm_n, 0);
    chk("rst busy", busy, 0);
    chk("rst period_end", period_end, 0);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a); #1;
      chk($sformatf("rst rd_data[%0d]", a), rd_data, 0);
    end
    rst = 1'b0;

`ifndef PWM_DEADTIME_EN
    foreach (vt[i]) begin
      do_reset();
      start(vt[i].ps, vt[i].per, vt[i].duty, vt[i].ctrl);
      sync();
      measure(0, 2'd0, 8'd0, 0, 2'd0, 8'd0, len, hi, nhi, both, b2);
      chk($sformatf("v%0d len", i), len, vt[i].len);
      chk($sformatf("v%0d high", i), hi, vt[i].hi);
      chk($sformatf("v%0d pwm_n", i), nhi, 0);
      chk($sformatf("v%0d busy", i), busy, 1);
    end

    // DUTY written mid-period waits for the wrap; written in the wrap cycle it is bypassed
    do_reset();
    start(8'd0, 8'd9, 8'd3, 8'd1);
    sync();
    measure(6, 2'd3, 8'd7, 0, 2'd0, 8'd0, len, hi, nhi, both, b2);
    chk("mid-write cur high", hi, 3);
    rd_addr = 2'd3; #1;
    chk("shadow readback", rd_data, 7);
    measure(10, 2'd3, 8'd2, 0, 2'd0, 8'd0, len, hi, nhi, both, b2);
    chk("mid-write next high", hi, 7);
    measure(0, 2'd0, 8'd0, 0, 2'd0, 8'd0, len, hi, nhi, both, b2);
    chk("wrap-write bypass high", hi, 2);

    // Disable then re-enable inside one period: no counter restart
    measure(3, 2'd0, 8'd0, 6, 2'd0, 8'd1, len, hi, nhi, both, b2);
    chk("stop/resume busy", b2, 1);
    chk("stop/resume len", len, 10);

    // Disable at cnt=4: period completes, one period_end, then idle
    measure(5, 2'd0, 8'd0, 8, 2'd0, 8'd0, len, hi, nhi, both, b2);
    chk("stopping busy", b2, 1);
    chk("stopping len", len, 10);
    chk("stopping high", hi, 2);
    cnt_pe = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (period_end) cnt_pe++;
    end
    chk("idle period_end count", cnt_pe, 0);
    chk("idle busy", busy, 0);
    chk("idle pwm_out", pwm_out, 0);

    // Asynchronous reset in a wrap cycle with inverted polarity
    start(8'd0, 8'd9, 8'd3, 8'd3);
    sync();
    chk("pre-rst pwm_out", pwm_out, 1);
    rst = 1'b1; #1;
    chk("async rst pwm_out", pwm_out, 0);
    chk("async rst busy", busy, 0);
    chk("async rst period_end", period_end, 0);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a); #1;
      chk($sformatf("async rst rd_data[%0d]", a), rd_data, 0);
    end
    @(negedge clk); rst = 1'b0;
    cnt_pe = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (busy || period_end) cnt_pe++;
    end
    chk("post-rst stays idle", cnt_pe, 0);
`else
    // Dead time: 5-clk raw high / 5-clk raw low, DEAD_CYCLES=2
    do_reset();
    start(8'd0, 8'd9, 8'd5, 8'd1);
    sync();
    measure(0, 2'd0, 8'd0, 0, 2'd0, 8'd0, len, hi, nhi, both, b2);
    chk("dt len", len, 10);
    chk("dt pwm_out high", hi, 3);
    chk("dt pwm_n high", nhi, 3);
    chk("dt overlap", both, 0);
    chk("dt gap cycles", len - hi - nhi, 4);
    wr(2'd0, 8'd0);
    sync();
    repeat (3) @(negedge clk);
    chk("dt idle pwm_out", pwm_out, 0);
    chk("dt idle pwm_n", pwm_n, 0);
    chk("dt idle busy", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
